// File: rtl/sha_pkg.sv
// sha_pkg: shared types and helpers for the SHA3 digest streamer
package sha_pkg;

    typedef enum logic [1:0] {SHA3_224, SHA3_256, SHA3_384, SHA3_512} sha_mode_t;
    typedef enum logic {IDLE, STREAM} st_t;
    typedef logic [63:0] lane_t;
    typedef lane_t [0:4][0:4] keccak_state_t;

    function automatic lane_t lane_bswap(lane_t l);
        lane_t r;
        for (int i = 0; i < 8; i++) r[8*i +: 8] = l[56-8*i +: 8];
        return r;
    endfunction

    // 32 wraps to 0 in five bits; callers only use beats-1, which is then 31
    function automatic logic [4:0] digest_beats(sha_mode_t m);
        return m == SHA3_224 ? 5'd14 : m == SHA3_256 ? 5'd16 : m == SHA3_384 ? 5'd24 : 5'd0;
    endfunction

endpackage

// File: rtl/sha_digest_streamer.sv
// sha_digest_streamer: captures the Keccak state and streams the SHA3 digest as 16-bit AXI-Stream beats (optional drop counter: SHA_DIGEST_OVERRUN_CNT_EN)
module sha_digest_streamer
    import sha_pkg::*;
#(
    parameter int DATA_W    = 16,
    parameter int CAP_LANES = 8
) (
    input  logic              ACLK,
    input  logic              ARESET,
    input  keccak_state_t     state_in,
    input  logic              state_valid,
    input  logic [1:0]        mode_id,
    output logic [DATA_W-1:0] m_axis_tdata,
    output logic              m_axis_tvalid,
    input  logic              m_axis_tready,
    output logic              m_axis_tlast,
    output logic              busy,
    output logic              overrun
`ifdef SHA_DIGEST_OVERRUN_CNT_EN
    ,
    output logic [7:0]        drop_cnt
`endif
);

    if (DATA_W != 16) begin : g_bad_dw
        $error("sha_digest_streamer: DATA_W must be 16");
    end

    typedef lane_t [0:CAP_LANES-1] cap_t;

    cap_t              r_cap;
    cap_t              w_cap;
    sha_mode_t         r_mode;
    st_t               r_state;
    logic [4:0]        r_cnt;
    logic [DATA_W-1:0] r_tdata;
    logic              r_tvalid;
    logic              r_tlast;
    logic              r_busy;
    logic              w_hs;
    logic              w_cap_en;
    logic              w_drop;
    logic [4:0]        w_nxt;
    logic [4:0]        w_last_idx;
    logic              w_unused_state;

    // Lanes stored byte-swapped so each beat is a plain MSB-first slice
    function automatic logic [15:0] beat_sel(cap_t c, logic [4:0] k);
        lane_t w;
        w = c[k[4:2]];
        return 16'(w >> {~k[1:0], 4'b0});
    endfunction

    assign w_unused_state = ^state_in;
    assign w_hs       = r_tvalid && m_axis_tready;
    assign w_cap_en   = state_valid && (r_state == IDLE || (w_hs && r_tlast));
    assign w_drop     = state_valid && r_state == STREAM && !(w_hs && r_tlast);
    assign w_nxt      = r_cnt + 5'd1;
    assign w_last_idx = digest_beats(r_mode) - 5'd1;

    // Byte-swapped view of the digest lanes, lane L = x + 5y
    always_comb begin
        for (int l = 0; l < CAP_LANES; l++) w_cap[l] = lane_bswap(state_in[l % 5][l / 5]);
    end

    // Capture / stream FSM with registered beat mux
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_state  <= IDLE;
            r_cap    <= '0;
            r_mode   <= SHA3_224;
            r_cnt    <= '0;
            r_tdata  <= '0;
            r_tvalid <= 1'b0;
            r_tlast  <= 1'b0;
            r_busy   <= 1'b0;
        end else if (w_cap_en) begin
            r_state  <= STREAM;
            r_cap    <= w_cap;
            r_mode   <= sha_mode_t'(mode_id);
            r_cnt    <= '0;
            r_tdata  <= w_cap[0][63:48];
            r_tvalid <= 1'b1;
            r_tlast  <= 1'b0;
            r_busy   <= 1'b1;
        end else if (w_hs && r_tlast) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_tvalid <= 1'b0;
            r_tlast  <= 1'b0;
            r_busy   <= 1'b0;
        end else if (w_hs) begin
            r_cnt    <= w_nxt;
            r_tdata  <= beat_sel(r_cap, w_nxt);
            r_tlast  <= w_nxt == w_last_idx;
        end
    end

`ifdef SHA_DIGEST_OVERRUN_CNT_EN
    logic [7:0] r_drop_cnt;

    // Saturating count of dropped capture strobes
    always_ff @(posedge ACLK) begin
        if (ARESET) r_drop_cnt <= '0;
        else if (w_drop && r_drop_cnt != 8'hFF) r_drop_cnt <= r_drop_cnt + 8'd1;
    end

    assign drop_cnt = r_drop_cnt;
    assign overrun  = r_drop_cnt != 8'd0;
`else
    logic r_overrun;

    // Sticky flag for a dropped capture strobe
    always_ff @(posedge ACLK) begin
        if (ARESET) r_overrun <= 1'b0;
        else if (w_drop) r_overrun <= 1'b1;
    end

    assign overrun = r_overrun;
`endif

    assign m_axis_tdata  = r_tdata;
    assign m_axis_tvalid = r_tvalid;
    assign m_axis_tlast  = r_tlast;
    assign busy          = r_busy;

endmodule

// File: tb/tb_sha_digest_streamer.sv
// tb_sha_digest_streamer: directed self-checking bench for sha_digest_streamer
module tb_sha_digest_streamer;
    import sha_pkg::*;

    logic          ACLK = 1'b0;
    logic          ARESET = 1'b1;
    keccak_state_t state_in = '0;
    logic          state_valid = 1'b0;
    logic [1:0]    mode_id = 2'd0;
    logic [15:0]   m_axis_tdata;
    logic          m_axis_tvalid;
    logic          m_axis_tready = 1'b0;
    logic          m_axis_tlast;
    logic          busy;
    logic          overrun;
`ifdef SHA_DIGEST_OVERRUN_CNT_EN
    logic [7:0]    drop_cnt;
`endif

    int            n_cmp = 0;
    int            n_bad = 0;
    logic [15:0]   exp_beat [0:31];
    keccak_state_t cnt_st;
    keccak_state_t sha_st;
    logic [255:0]  empty_dg = 256'ha7ffc6f8bf1ed76651c14756a061d662f580ff4de43b49fa82d80a4b80f8434a;

    sha_digest_streamer dut (
        .ACLK          (ACLK),
        .ARESET        (ARESET),
        .state_in      (state_in),
        .state_valid   (state_valid),
        .mode_id       (mode_id),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tlast  (m_axis_tlast),
        .busy          (busy),
        .overrun       (overrun)
`ifdef SHA_DIGEST_OVERRUN_CNT_EN
        ,
        .drop_cnt      (drop_cnt)
`endif
    );

    always #5 ACLK = ~ACLK;

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic fill_count();
        for (int k = 0; k < 32; k++) exp_beat[k] = {8'(2*k), 8'(2*k+1)};
    endtask

    task automatic send(input keccak_state_t s, input logic [1:0] m);
        state_in = s;
        mode_id = m;
        state_valid = 1'b1;
        tick();
        state_valid = 1'b0;
        check("lat_tvalid", m_axis_tvalid, 1);
        check("lat_busy", busy, 1);
    endtask

    task automatic idle_chk();
        check("idle_tvalid", m_axis_tvalid, 0);
        check("idle_busy", busy, 0);
    endtask

    task automatic collect(input int n_total, input int n_take, input bit stall, input int inj, input logic [1:0] inj_mode);
        int cnt = 0;
        int cyc = 0;
        while (cnt < n_take && cyc < 400) begin
            m_axis_tready = stall ? (cyc % 4 == 0 || cyc % 4 == 3) : 1'b1;
            state_valid = 1'b0;
            check("tvalid", m_axis_tvalid, 1);
            check("tdata", m_axis_tdata, exp_beat[cnt]);
            check("tlast", m_axis_tlast, cnt == n_total - 1);
            if (m_axis_tvalid && m_axis_tready) begin
                if (cnt == inj) begin
                    state_valid = 1'b1;
                    mode_id = inj_mode;
                end
                cnt++;
            end
            tick();
            cyc++;
        end
        state_valid = 1'b0;
        m_axis_tready = 1'b1;
        check("beats", cnt, n_take);
    endtask

    initial begin
        for (int l = 0; l < 25; l++) cnt_st[l % 5][l / 5] = {8{8'(8*l)}} + 64'h0706050403020100;
        for (int l = 0; l < 25; l++) sha_st[l % 5][l / 5] = 64'hdeadbeef00000000 | 64'(l);
        sha_st[0][0] = 64'h66d71ebff8c6ffa7;
        sha_st[1][0] = 64'h62d661a05647c151;
        sha_st[2][0] = 64'hfa493be44dff80f5;
        sha_st[3][0] = 64'h4a43f8804b0ad882;
        fill_count();
        tick();
        tick();
        check("rst_tdata", m_axis_tdata, 0);
        check("rst_tvalid", m_axis_tvalid, 0);
        check("rst_tlast", m_axis_tlast, 0);
        check("rst_busy", busy, 0);
        check("rst_overrun", overrun, 0);
        ARESET = 1'b0;
        m_axis_tready = 1'b1;
        tick();
        idle_chk();
        send(cnt_st, 2'd1);
        collect(16, 16, 1'b0, -1, 2'd0);
        idle_chk();
        send(cnt_st, 2'd0);
        collect(14, 14, 1'b0, -1, 2'd0);
        idle_chk();
        send(cnt_st, 2'd3);
        collect(32, 32, 1'b0, -1, 2'd0);
        idle_chk();
        send(cnt_st, 2'd1);
        collect(16, 16, 1'b1, -1, 2'd0);
        idle_chk();
        send(cnt_st, 2'd1);
        collect(16, 16, 1'b0, 15, 2'd0);
        check("b2b_tvalid", m_axis_tvalid, 1);
        collect(14, 14, 1'b0, -1, 2'd0);
        idle_chk();
        check("b2b_overrun", overrun, 0);
        send(cnt_st, 2'd1);
        collect(16, 16, 1'b0, 5, 2'd3);
        idle_chk();
        check("drop_overrun", overrun, 1);
`ifdef SHA_DIGEST_OVERRUN_CNT_EN
        check("drop_cnt", drop_cnt, 1);
`endif
        send(cnt_st, 2'd1);
        collect(16, 7, 1'b0, -1, 2'd0);
        ARESET = 1'b1;
        tick();
        ARESET = 1'b0;
        check("mid_rst_tvalid", m_axis_tvalid, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_overrun", overrun, 0);
        check("mid_rst_tlast", m_axis_tlast, 0);
        tick();
        idle_chk();
        send(cnt_st, 2'd1);
        collect(16, 16, 1'b0, -1, 2'd0);
        idle_chk();
        for (int k = 0; k < 16; k++) exp_beat[k] = empty_dg[255-16*k -: 16];
        send(sha_st, 2'd1);
        collect(16, 16, 1'b0, -1, 2'd0);
        idle_chk();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
